// File: rtl/packet_seq_pkg.sv
// packet_seq_pkg: shared FSM encoding, tag field layout and default sizing for packet_sequencer.
// Rev 1.0
`default_nettype none

package packet_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int          TAG_W     = 3;
  localparam logic [TAG_W-1:0] TAG_SKIP = 3'b000;
  localparam int          DEF_PKT_W = 38;
  localparam int          DEF_DEPTH = 32;

endpackage

`default_nettype wire

// File: rtl/packet_seq_mem.sv
// packet_seq_mem: DEPTH x PKT_W program store, one synchronous write port and one asynchronous read port.
// Rev 1.0
`default_nettype none

module packet_seq_mem
  import packet_seq_pkg::*;
#(
  parameter  int PKT_W = DEF_PKT_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PKT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PKT_W-1:0] rdata
);

  // Program contents deliberately survive reset.
  logic [PKT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/packet_sequencer.sv
// packet_sequencer: replays LEN program entries as valid/ready packets, optionally looping.
// Rev 1.0 -- define PACKET_SEQ_SKIP_EN to silently step over entries tagged TAG_SKIP.
`default_nettype none

module packet_sequencer
  import packet_seq_pkg::*;
#(
  parameter  int PKT_W = DEF_PKT_W,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PC_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [PC_W-1:0]  waddr,
  input  logic [PKT_W-1:0] wdata,
  input  logic             start,
  input  logic             abort,
  input  logic [PC_W:0]    len,
  input  logic             loop,
  input  logic             pkt_ready,
  output logic             pkt_valid,
  output logic [PKT_W-1:0] pkt_data,
  output logic [PC_W-1:0]  pc_out,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [PC_W:0]    len_q, len_nxt;
  logic             loop_q, loop_nxt;
  logic             valid_q, valid_nxt;
  logic [PKT_W-1:0] data_q, data_nxt;
  logic [PC_W-1:0]  pc_out_q, pc_out_nxt;
  logic             done_q, done_nxt;

  logic [PKT_W-1:0] rdata;
  logic             skip;
  logic             can_issue;
  logic             is_last;
  logic [PC_W:0]    len_clamped;

  packet_seq_mem #(
    .PKT_W (PKT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (pc),
    .rdata (rdata)
  );

`ifdef PACKET_SEQ_SKIP_EN
  assign skip = (rdata[PKT_W-1 -: TAG_W] == TAG_SKIP);
`else
  assign skip = 1'b0;
`endif

  assign can_issue   = !valid_q || pkt_ready;
  assign is_last     = (({1'b0, pc} + (PC_W+1)'(1)) == len_q);
  assign len_clamped = (len > (PC_W+1)'(DEPTH)) ? (PC_W+1)'(DEPTH) : len;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    len_nxt    = len_q;
    loop_nxt   = loop_q;
    valid_nxt  = valid_q;
    data_nxt   = data_q;
    pc_out_nxt = pc_out_q;
    done_nxt   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_RUN;
            pc_nxt    = '0;
            len_nxt   = len_clamped;
            loop_nxt  = loop;
          end
        end
      end
      ST_RUN: begin
        if (can_issue) begin
          // A skipped entry still retires the previous packet, so valid drops.
          if (skip) begin
            valid_nxt = 1'b0;
          end else begin
            data_nxt   = rdata;
            pc_out_nxt = pc;
            valid_nxt  = 1'b1;
          end
          if (is_last) begin
            if (loop_q) begin
              pc_nxt = '0;
            end else begin
              state_nxt = ST_DRAIN;
            end
          end else begin
            pc_nxt = pc + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (can_issue) begin
          valid_nxt = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_nxt = ST_IDLE;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      pc_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      len_q    <= len_nxt;
      loop_q   <= loop_nxt;
      valid_q  <= valid_nxt;
      data_q   <= data_nxt;
      pc_out_q <= pc_out_nxt;
      done_q   <= done_nxt;
    end
  end

  assign pkt_valid = valid_q;
  assign pkt_data  = data_q;
  assign pc_out    = pc_out_q;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

endmodule

`default_nettype wire

// File: doc/packet_sequencer.md
PACKET_SEQUENCER -- requirements
Module: packet_sequencer

Interface
REQ-001 SHALL have parameter PKT_W, default 38, packet width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of program entries; PC_W = clog2(DEPTH).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port WE  input  1  program-memory write enable.
REQ-006 SHALL have port WADDR  input  PC_W  write address.
REQ-007 SHALL have port WDATA  input  PKT_W  write data.
REQ-008 SHALL have port START  input  1  begin sequence, sampled in IDLE only.
REQ-009 SHALL have port ABORT  input  1  terminate sequence.
REQ-010 SHALL have port LEN  input  PC_W+1  entries to issue, sampled on accepted START.
REQ-011 SHALL have port LOOP  input  1  wrap mode, sampled on accepted START.
REQ-012 SHALL have port PKT_READY  input  1  consumer ready.
REQ-013 SHALL have port PKT_VALID  output  1  PKT_DATA valid.
REQ-014 SHALL have port PKT_DATA  output  PKT_W  registered packet.
REQ-015 SHALL have port PC_OUT  output  PC_W  index of entry held in PKT_DATA.
REQ-016 SHALL have ports BUSY (output 1, state != IDLE) and DONE (output 1, one-cycle pulse).

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN.
REQ-018 IDLE: START=1, LEN>0 -> RUN with PC=0; START=1, LEN=0 -> DONE pulse next cycle, stay IDLE; LEN>DEPTH SHALL be clamped to DEPTH.
REQ-019 RUN: when PKT_VALID=0 or PKT_READY=1, SHALL load mem[PC] into PKT_DATA, PC into PC_OUT, set PKT_VALID=1, advance PC; first PKT_VALID two cycles after accepted START.
REQ-020 PKT_DATA/PC_OUT SHALL hold stable while PKT_VALID=1 and PKT_READY=0.
REQ-021 On issue of entry LEN-1: LOOP=1 -> PC wraps to 0, stay RUN; LOOP=0 -> DRAIN.
REQ-022 DRAIN: on PKT_READY=1 SHALL clear PKT_VALID, pulse DONE, go IDLE.
REQ-023 PKT_VALID SHALL clear only on handshake (PKT_READY=1 with no new load) or ABORT.
REQ-024 ABORT=1 in any state SHALL clear PKT_VALID, go IDLE next cycle, no DONE pulse; ABORT overrides START same cycle.
REQ-025 Writes SHALL be synchronous; simultaneous write and fetch of same address SHALL return old data; writes allowed in any state.
REQ-026 START while BUSY=1 SHALL be ignored.

Reset
REQ-027 RST_N=0 SHALL force IDLE, PC=0, PKT_VALID=0, PKT_DATA=0, PC_OUT=0, DONE=0, BUSY=0 immediately; memory contents SHALL NOT be reset.
REQ-028 Reset mid-sequence SHALL discard the sequence; next START restarts at entry 0.

Configuration
REQ-029 With PACKET_SEQ_SKIP_EN defined, entries whose top 3 bits equal 3'b000 SHALL consume one PC step and one cycle, count toward LEN, and never raise PKT_VALID; a skipped entry LEN-1 with LOOP=0 SHALL still end the sequence (DONE once PKT_VALID clears).
REQ-030 Without PACKET_SEQ_SKIP_EN all entries SHALL be issued regardless of content.

Structure
REQ-031 Package packet_seq_pkg SHALL hold state enum, TAG_W=3, TAG_SKIP=3'b000, default PKT_W/DEPTH.
REQ-032 Sub-module packet_seq_mem SHALL hold the DEPTH x PKT_W array: one sync write port, one async read port.

Verification
REQ-033 Write entries 0..3 = 4,5,6,7; START, LEN=4, LOOP=0, READY=1 -> PKT_DATA 4,5,6,7 on consecutive cycles, PC_OUT 0..3, DONE pulse once, BUSY low after.
REQ-034 Same program, READY low 3 cycles at entry 1 -> PKT_DATA=5 held 4 cycles, no entry lost or duplicated.
REQ-035 LEN=3, LOOP=1, READY=1 for 9 handshakes -> PC_OUT 0,1,2,0,1,2,0,1,2, no DONE; ABORT -> PKT_VALID=0 next cycle, no DONE.
REQ-036 RST_N low mid-sequence at PC=2 -> outputs zero at once; START afterwards issues entry 0; memory data intact.
REQ-037 PACKET_SEQ_SKIP_EN, entry 1 top bits 000, LEN=4 -> data for entries 0,2,3 only, DONE once; without macro all 4 issued.
REQ-038 START with LEN=0 -> no PKT_VALID, DONE pulse next cycle.
